// File: rtl/seg7_pkg.sv
// Shared types and sizes for the 4-digit 7-segment display path.
// Digit 0 is the rightmost digit and occupies the lowest nibble of a display word.
package seg7_pkg;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;

  typedef logic [1:0]                 digit_idx_t;
  typedef logic [DIGITS*NIBBLE_W-1:0] disp_word_t;
  typedef logic [DIGITS-1:0]          dots_t;

  // Extracts the nibble that belongs to one digit of a display word.
  function automatic logic [NIBBLE_W-1:0] digit_nibble(input disp_word_t word,
                                                       input digit_idx_t idx);
    return word[NIBBLE_W*idx +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/seg7_refresh_div.sv
// Free-running divider that emits a one-cycle tick every REFRESH_DIV clocks.
// A value of 1 gives a tick on every cycle.
module seg7_refresh_div #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV + 1)
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed scan of a 4-digit display word, with new words committed
// only on frame boundaries so a frame never mixes old and new digits.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV + 1)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        BLANK,
  output logic [1:0]  SEG_SELECT,
  output logic [3:0]  BIN_OUT,
  output logic        DOT_OUT,
  output logic        PENDING,
  output logic        FRAME_DONE
);

  logic       tick;
  logic       frame_end;
  digit_idx_t idx;
  disp_word_t active_word;
  disp_word_t pending_word;
  dots_t      active_dots;
  dots_t      pending_dots;
  logic       pending_valid;

  seg7_refresh_div #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_div (
    .clk   (CLK),
    .rst_n (RESET),
    .tick  (tick)
  );

  assign frame_end = tick && (idx == digit_idx_t'(DIGITS - 1));
  assign PENDING   = pending_valid;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx <= '0;
    end else if (tick) begin
      idx <= idx + 1'b1;
    end
  end

  // Commit uses the pending contents from before this edge, so a LOAD landing
  // on the boundary itself is held over to the following frame.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      active_word   <= '0;
      active_dots   <= '0;
      pending_word  <= '0;
      pending_dots  <= '0;
      pending_valid <= 1'b0;
      FRAME_DONE    <= 1'b0;
    end else begin
      FRAME_DONE <= frame_end;
      if (frame_end && pending_valid) begin
        active_word <= pending_word;
        active_dots <= pending_dots;
      end
      if (LOAD) begin
        pending_word  <= DATA_IN;
        pending_dots  <= DOTS_IN;
        pending_valid <= 1'b1;
      end else if (frame_end) begin
        pending_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      SEG_SELECT <= '0;
      BIN_OUT    <= '0;
      DOT_OUT    <= 1'b0;
    end else begin
      SEG_SELECT <= idx;
      BIN_OUT    <= BLANK ? 4'h0 : digit_nibble(active_word, idx);
      DOT_OUT    <= BLANK ? 1'b0 : active_dots[idx];
    end
  end

endmodule
